// File: rtl/vga_plot_sched_pkg.sv
// Shared widths, screen limits, colour names and types for the VGA plot scheduler.
package vga_plot_sched_pkg;

  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned CW    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PIX_W = XW + YW + CW;

  localparam logic [XW-1:0] XMAX = 8'd159;
  localparam logic [YW-1:0] YMAX = 7'd119;

  localparam logic [CW-1:0] COL_BLACK   = 3'b000;
  localparam logic [CW-1:0] COL_BLUE    = 3'b001;
  localparam logic [CW-1:0] COL_GREEN   = 3'b010;
  localparam logic [CW-1:0] COL_CYAN    = 3'b011;
  localparam logic [CW-1:0] COL_RED     = 3'b100;
  localparam logic [CW-1:0] COL_MAGENTA = 3'b101;
  localparam logic [CW-1:0] COL_YELLOW  = 3'b110;
  localparam logic [CW-1:0] COL_WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // Arbiter pointer: names the source that wins the next tie.
  typedef enum logic {
    SRC_FIFO = 1'b0,
    SRC_FILL = 1'b1
  } src_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
  } pixel_t;

  function automatic logic in_screen(input pixel_t p);
    return (p.x <= XMAX) && (p.y <= YMAX);
  endfunction

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] x);
    return (x > XMAX) ? XMAX : x;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] y);
    return (y > YMAX) ? YMAX : y;
  endfunction

endpackage

// File: rtl/vga_plot_sched_fifo.sv
// Small pixel FIFO: registered storage, wrapping pointers, count-based full/empty.
// Head entry is presented combinationally on rdata_o; a pop consumes it at the edge.
module vga_plot_sched_fifo
  import vga_plot_sched_pkg::*;
#(
  parameter int unsigned DEPTH_P = DEPTH
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [PIX_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW    = $clog2(DEPTH_P);
  localparam int unsigned CNT_W = AW + 1;

  logic [PIX_W-1:0] mem_q [DEPTH_P];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH_P));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path leaves one unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vga_plot_sched.sv
// Plot-port scheduler for the VGA adapter: merges a buffered CPU pixel stream
// with a rectangle-fill engine through a two-way round-robin arbiter, drops
// off-screen CPU pixels, and drives registered x/y/colour/plot.
module vga_plot_sched
  import vga_plot_sched_pkg::*;
#(
  parameter int unsigned DEPTH_P = DEPTH
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          px_req_i,
  input  logic [XW-1:0] px_x_i,
  input  logic [YW-1:0] px_y_i,
  input  logic [CW-1:0] px_colour_i,
  output logic          px_ack_o,
  output logic          fifo_full_o,
  input  logic          fill_req_i,
  input  logic [XW-1:0] fill_x0_i,
  input  logic [XW-1:0] fill_x1_i,
  input  logic [YW-1:0] fill_y0_i,
  input  logic [YW-1:0] fill_y1_i,
  input  logic [CW-1:0] fill_colour_i,
  output logic          fill_busy_o,
  output logic          fill_done_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [CW-1:0] colour_o,
  output logic          plot_o
);

  // ---------------------------------------------------------------- FIFO
  logic             fifo_empty;
  logic             push;
  logic [PIX_W-1:0] fifo_rdata;
  pixel_t           head;
  pixel_t           px_in;

  assign px_in    = '{x: px_x_i, y: px_y_i, colour: px_colour_i};
  assign push     = px_req_i & ~fifo_full_o;
  assign px_ack_o = push;
  assign head     = pixel_t'(fifo_rdata);

  logic grant_fifo, grant_fill;

  vga_plot_sched_fifo #(
    .DEPTH_P (DEPTH_P)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push),
    .wdata_i  (px_in),
    .pop_i    (grant_fifo),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full_o),
    .empty_o  (fifo_empty)
  );

  // ---------------------------------------------------------- fill engine
  fill_state_e   state_q, state_d;
  logic [XW-1:0] fx0_q, fx0_d;
  logic [XW-1:0] fx1_q, fx1_d;
  logic [YW-1:0] fy1_q, fy1_d;
  logic [CW-1:0] fcol_q, fcol_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;

  logic [XW-1:0] x1_eff;
  logic [YW-1:0] y1_eff;
  logic          fill_empty;
  logic          start_fill;
  logic          last_pix;

  // Bounds are clamped to the screen once, at start, so RUN only ever issues visible pixels.
  assign x1_eff     = clamp_x(fill_x1_i);
  assign y1_eff     = clamp_y(fill_y1_i);
  assign fill_empty = (fill_x0_i > x1_eff) || (fill_y0_i > y1_eff);
  assign start_fill = (state_q == IDLE) && fill_req_i;
  assign last_pix   = (cx_q == fx1_q) && (cy_q == fy1_q);

  // Fill FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Fill FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fill_req_i) state_d = fill_empty ? DONE : RUN;
      RUN:     if (grant_fill && last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill FSM output decode.
  always_comb begin
    fill_busy_o = (state_q != IDLE);
    fill_done_o = (state_q == DONE);
  end

  // Fill bounds latch and raster counters (x inner, y outer).
  always_comb begin
    fx0_d  = fx0_q;
    fx1_d  = fx1_q;
    fy1_d  = fy1_q;
    fcol_d = fcol_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    if (start_fill) begin
      fx0_d  = fill_x0_i;
      fx1_d  = x1_eff;
      fy1_d  = y1_eff;
      fcol_d = fill_colour_i;
      cx_d   = fill_x0_i;
      cy_d   = fill_y0_i;
    end else if (grant_fill) begin
      if (cx_q == fx1_q) begin
        cx_d = fx0_q;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Fill datapath registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fx0_q  <= '0;
      fx1_q  <= '0;
      fy1_q  <= '0;
      fcol_q <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
    end else begin
      fx0_q  <= fx0_d;
      fx1_q  <= fx1_d;
      fy1_q  <= fy1_d;
      fcol_q <= fcol_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
    end
  end

  // ------------------------------------------------------------- arbiter
  src_e rr_q, rr_d;
  logic fifo_cand, fill_cand;

  assign fifo_cand = ~fifo_empty;
  assign fill_cand = (state_q == RUN);

  // Round-robin grant: a lone candidate always wins; on a tie rr_q decides.
  always_comb begin
    grant_fifo = 1'b0;
    grant_fill = 1'b0;
    if (fifo_cand && fill_cand) begin
      if (rr_q == SRC_FIFO) grant_fifo = 1'b1;
      else                  grant_fill = 1'b1;
    end else begin
      grant_fifo = fifo_cand;
      grant_fill = fill_cand;
    end
  end

  // Pointer moves to the other source after every grant, including a dropped off-screen pop.
  always_comb begin
    rr_d = rr_q;
    if (grant_fifo)      rr_d = SRC_FILL;
    else if (grant_fill) rr_d = SRC_FIFO;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rr_q <= SRC_FIFO;
    else           rr_q <= rr_d;
  end

  // ------------------------------------------------------ output registers
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] colour_q, colour_d;
  logic          plot_q, plot_d;

  // Plot selection: x/y/colour hold their last values whenever nothing is plotted.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    if (grant_fifo) begin
      if (in_screen(head)) begin
        plot_d   = 1'b1;
        x_d      = head.x;
        y_d      = head.y;
        colour_d = head.colour;
      end
    end else if (grant_fill) begin
      plot_d   = 1'b1;
      x_d      = cx_q;
      y_d      = cy_q;
      colour_d = fcol_q;
    end
  end

  // Plot port registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;
  assign plot_o   = plot_q;

endmodule

// File: tb/tb_vga_plot_sched.sv
// Directed bench for vga_plot_sched: reset, single pixel, FIFO full, fill,
// contention and screen-boundary cases with hand-derived expectations.
module tb_vga_plot_sched;
  import vga_plot_sched_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          px_req;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [CW-1:0] px_colour;
  logic          px_ack;
  logic          fifo_full;
  logic          fill_req;
  logic [XW-1:0] fill_x0, fill_x1;
  logic [YW-1:0] fill_y0, fill_y1;
  logic [CW-1:0] fill_colour;
  logic          fill_busy, fill_done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;

  always #5 clk = ~clk;

  vga_plot_sched dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .px_req_i      (px_req),
    .px_x_i        (px_x),
    .px_y_i        (px_y),
    .px_colour_i   (px_colour),
    .px_ack_o      (px_ack),
    .fifo_full_o   (fifo_full),
    .fill_req_i    (fill_req),
    .fill_x0_i     (fill_x0),
    .fill_x1_i     (fill_x1),
    .fill_y0_i     (fill_y0),
    .fill_y1_i     (fill_y1),
    .fill_colour_i (fill_colour),
    .fill_busy_o   (fill_busy),
    .fill_done_o   (fill_done),
    .x_o           (x),
    .y_o           (y),
    .colour_o      (colour),
    .plot_o        (plot)
  );

  int checks = 0;
  int errors = 0;

  // Plot / done monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [31:0] log_q[$];
  int          stamp_q[$];
  int          done_cnt = 0;
  int          done_stamp = 0;

  always @(negedge clk) begin
    cyc++;
    if (plot === 1'b1) begin
      log_q.push_back({14'd0, x, y, colour});
      stamp_q.push_back(cyc);
    end
    if (fill_done === 1'b1) begin
      done_cnt++;
      done_stamp = cyc;
    end
  end

  function automatic logic [31:0] pix(input int px, input int py, input int pc);
    return {14'd0, 8'(px), 7'(py), 3'(pc)};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int stamp_at(input int i);
    return (i < stamp_q.size()) ? stamp_q[i] : -1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    stamp_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_fill(input int x0, input int x1, input int y0, input int y1, input int c);
    fill_x0     = 8'(x0);
    fill_x1     = 8'(x1);
    fill_y0     = 7'(y0);
    fill_y1     = 7'(y1);
    fill_colour = 3'(c);
    fill_req    = 1'b1;
    tick();
    fill_req    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic wait_plots(input string tag, input int count, input int budget);
    int n = 0;
    while (log_q.size() < count && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(log_q.size() >= count), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic acks_exp [9];

  initial begin
    reset_n = 1'b0; px_req = 1'b0; px_x = '0; px_y = '0; px_colour = '0;
    fill_req = 1'b0; fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_colour = '0;
    #2;
    // Reset state
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_busy", 32'(fill_busy), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 1: reset mid-fill after 5 plots of a 4x4 box
    clear_log();
    start_fill(0, 3, 0, 3, COL_BLUE);
    wait_plots("t1_wait5", 5, 20);
    check("t1_fifth_pix", log_at(4), pix(0, 1, 1));
    check("t1_plot_before", 32'(plot), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_async_plot", 32'(plot), 32'd0);
    check("t1_async_x", 32'(x), 32'd0);
    check("t1_async_y", 32'(y), 32'd0);
    check("t1_async_colour", 32'(colour), 32'd0);
    check("t1_async_busy", 32'(fill_busy), 32'd0);
    check("t1_async_done", 32'(fill_done), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("t1_no_done", 32'(done_cnt), 32'd0);
    check("t1_no_more_plots", 32'(log_q.size()), 32'd5);

    // 2: single pixel, plot one cycle after the push edge
    clear_log();
    px_x = 8'd10; px_y = 7'd20; px_colour = COL_CYAN; px_req = 1'b1;
    #1;
    check("t2_ack", 32'(px_ack), 32'd1);
    tick();
    px_req = 1'b0;
    check("t2_no_bypass", 32'(plot), 32'd0);
    tick();
    check("t2_plot", 32'(plot), 32'd1);
    check("t2_x", 32'(x), 32'd10);
    check("t2_y", 32'(y), 32'd20);
    check("t2_colour", 32'(colour), 32'd3);
    tick();
    check("t2_plot_once", 32'(plot), 32'd0);
    check("t2_count", 32'(log_q.size()), 32'd1);

    // 4: fill 0..2 x 0..1 colour 7, raster order, back-to-back
    clear_log();
    start_fill(0, 2, 0, 1, COL_WHITE);
    check("t4_busy", 32'(fill_busy), 32'd1);
    wait_done("t4_done_seen", 20);
    repeat (3) tick();
    check("t4_count", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("t4_pix", log_at(i), pix(i % 3, i / 3, 7));
      check("t4_consec", 32'(stamp_at(i) - stamp_at(0)), 32'(i));
    end
    check("t4_done_once", 32'(done_cnt), 32'd1);
    check("t4_done_at_last", 32'(done_stamp), 32'(stamp_at(5)));
    check("t4_idle", 32'(fill_busy), 32'd0);

    // 3: FIFO fills while the fill engine competes for the port
    clear_log();
    start_fill(0, 9, 0, 0, COL_BLACK);
    acks_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    begin
      int k = 0;
      for (int a = 0; a < 9; a++) begin
        px_x = 8'(100 + k); px_y = 7'd50; px_colour = COL_MAGENTA; px_req = 1'b1;
        #1;
        check("t3_ack", 32'(px_ack), 32'(acks_exp[a]));
        check("t3_full", 32'(fifo_full), 32'(!acks_exp[a]));
        if (px_ack) k++;
        tick();
      end
    end
    px_req = 1'b0;
    wait_done("t3_done_seen", 40);
    repeat (10) tick();
    begin
      int ci = 0;
      int fi = 0;
      foreach (log_q[i]) begin
        if (log_q[i][9:3] == 7'd50) begin
          check("t3_cpu_order", 32'(log_q[i][17:10]), 32'(100 + ci));
          ci++;
        end else begin
          fi++;
        end
      end
      check("t3_cpu_count", 32'(ci), 32'd8);
      check("t3_fill_count", 32'(fi), 32'd10);
    end

    // 5: contention, sources alternate while both have work
    clear_log();
    fill_x0 = 8'd0; fill_x1 = 8'd3; fill_y0 = 7'd0; fill_y1 = 7'd0; fill_colour = COL_GREEN;
    fill_req = 1'b1;
    px_x = 8'd50; px_y = 7'd60; px_colour = COL_YELLOW; px_req = 1'b1;
    #1;
    check("t5_ack0", 32'(px_ack), 32'd1);
    tick();
    fill_req = 1'b0;
    px_x = 8'd51;
    #1;
    check("t5_ack1", 32'(px_ack), 32'd1);
    tick();
    px_req = 1'b0;
    wait_done("t5_done_seen", 40);
    repeat (3) tick();
    check("t5_count", 32'(log_q.size()), 32'd6);
    check("t5_p0", log_at(0), pix(50, 60, 6));
    check("t5_p1", log_at(1), pix(0, 0, 2));
    check("t5_p2", log_at(2), pix(51, 60, 6));
    check("t5_p3", log_at(3), pix(1, 0, 2));
    check("t5_p4", log_at(4), pix(2, 0, 2));
    check("t5_p5", log_at(5), pix(3, 0, 2));
    check("t5_span", 32'(stamp_at(5) - stamp_at(0)), 32'd5);
    check("t5_done_at_last", 32'(done_stamp), 32'(stamp_at(5)));

    // 6a: off-screen CPU pixel is consumed without a plot
    clear_log();
    px_x = 8'd160; px_y = 7'd5; px_colour = COL_RED; px_req = 1'b1;
    #1;
    check("t6_oob_ack", 32'(px_ack), 32'd1);
    tick();
    px_req = 1'b0;
    repeat (4) tick();
    check("t6_oob_noplot", 32'(log_q.size()), 32'd0);
    px_x = 8'd7; px_y = 7'd8; px_colour = COL_CYAN; px_req = 1'b1;
    tick();
    px_req = 1'b0;
    repeat (3) tick();
    check("t6_next_count", 32'(log_q.size()), 32'd1);
    check("t6_next_pix", log_at(0), pix(7, 8, 3));

    // 6b: fill clipped at the right/bottom edge
    clear_log();
    start_fill(158, 200, 119, 119, COL_CYAN);
    wait_done("t6_clip_done", 20);
    repeat (3) tick();
    check("t6_clip_count", 32'(log_q.size()), 32'd2);
    check("t6_clip_p0", log_at(0), pix(158, 119, 3));
    check("t6_clip_p1", log_at(1), pix(159, 119, 3));

    // 6c: empty rectangle completes with no plots
    clear_log();
    start_fill(5, 3, 0, 0, COL_WHITE);
    check("t6_empty_done", 32'(fill_done), 32'd1);
    check("t6_empty_busy", 32'(fill_busy), 32'd1);
    tick();
    check("t6_empty_done_pulse", 32'(fill_done), 32'd0);
    check("t6_empty_idle", 32'(fill_busy), 32'd0);
    repeat (3) tick();
    check("t6_empty_noplot", 32'(log_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
